// File: rtl/operand_select.sv
// operand_select
//   Picks one operand per accepted transfer, either a register channel
//   (in_data[sel]) or the immediate field zero/sign-extended to WIDTH. The
//   chosen value goes into a 2-entry skid buffer, which has an output
//   register and a skid register. in_ready is registered, so it never
//   depends combinationally on out_ready.
//
// Ports
//   clk        sole clock, rising edge
//   reset_n    asynchronous active-low reset
//   in_data    NUM_IN packed channels, channel k at [k*WIDTH +: WIDTH]
//   immediate  immediate operand field
//   sel        register channel index
//   imm_en     1 = extended immediate, 0 = channel sel
//   sext       1 = sign-extend immediate, 0 = zero-extend
//   in_valid   upstream offers an operand
//   in_ready   block accepts an operand this cycle
//   out_data   selected operand (registered)
//   out_valid  out_data holds a valid operand
//   out_ready  downstream consumes out_data
//   sel_err    sticky flag: an out-of-range select was accepted
module operand_select #(
  parameter int WIDTH     = 16,
  parameter int NUM_IN    = 4,
  parameter int IMM_WIDTH = 8,
  parameter int SEL_W     = 4
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic [NUM_IN*WIDTH-1:0] in_data,
  input  logic [IMM_WIDTH-1:0]    immediate,
  input  logic [SEL_W-1:0]        sel,
  input  logic                    imm_en,
  input  logic                    sext,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [WIDTH-1:0]        out_data,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic                    sel_err
);

  typedef enum logic [1:0] {EMPTY, ONE, FULL} state_t;

  state_t           state, state_nx;
  logic [WIDTH-1:0] out_q, skid_q, out_nx, skid_nx;
  logic [WIDTH-1:0] imm_ext, chan_val, sel_val;
  logic             out_v, skid_v, rdy_q, err_q;
  logic             in_fire, out_fire, sel_oob;

  // Operand selection
  if (IMM_WIDTH == WIDTH) begin : g_imm_full
    assign imm_ext = immediate;
  end else begin : g_imm_ext
    assign imm_ext = {{(WIDTH-IMM_WIDTH){sext & immediate[IMM_WIDTH-1]}}, immediate};
  end

  always_comb begin
    chan_val = '0;
    for (int unsigned k = 0; k < NUM_IN; k++) begin
      if (32'(sel) == k) chan_val = in_data[k*WIDTH +: WIDTH];
    end
  end

  assign sel_oob = (32'(sel) >= 32'(NUM_IN));
  assign sel_val = imm_en ? imm_ext : (sel_oob ? '0 : chan_val);

  // Handshakes
  assign in_fire  = in_valid & rdy_q;
  assign out_fire = out_v & out_ready;

  // Skid buffer next state
  always_comb begin
    state_nx = state;
    out_nx   = out_q;
    skid_nx  = skid_q;
    unique case (state)
      EMPTY: begin
        if (in_fire) begin
          state_nx = ONE;
          out_nx   = sel_val;
        end
      end
      ONE: begin
        if (in_fire && out_fire) begin
          out_nx = sel_val;
        end else if (in_fire) begin
          state_nx = FULL;
          skid_nx  = sel_val;
        end else if (out_fire) begin
          state_nx = EMPTY;
        end
      end
      FULL: begin
        if (out_fire) begin
          state_nx = ONE;
          out_nx   = skid_q;
        end
      end
      default: state_nx = EMPTY;
    endcase
  end

  // Valid bits and in_ready are registered from next state. Because rdy_q
  // resets to 0, the first edge after reset only raises in_ready and no
  // transfer can happen on it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state  <= EMPTY;
      out_q  <= '0;
      skid_q <= '0;
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      rdy_q  <= 1'b0;
      err_q  <= 1'b0;
    end else begin
      state  <= state_nx;
      out_q  <= out_nx;
      skid_q <= skid_nx;
      out_v  <= (state_nx != EMPTY);
      skid_v <= (state_nx == FULL);
      rdy_q  <= (state_nx != FULL);
      err_q  <= err_q | (in_fire & ~imm_en & sel_oob);
    end
  end

  assign in_ready  = rdy_q;
  assign out_data  = out_q;
  assign out_valid = out_v;
  assign sel_err   = err_q;

  // skid_v mirrors FULL; it is kept as the skid register's own valid bit
  logic unused_skid_v;
  assign unused_skid_v = skid_v;

endmodule

// File: doc/operand_select.md
OPERAND_SELECT -- requirements
Module: operand_select

Interface
REQ-001 Parameter WIDTH, default 16, operand data width in bits.
REQ-002 Parameter NUM_IN, default 4, number of register-sourced operand channels; legal range 2..16.
REQ-003 Parameter IMM_WIDTH, default 8, immediate field width; legal range 1..WIDTH.
REQ-004 Parameter SEL_W, default 4, select width; SHALL satisfy 2**SEL_W >= NUM_IN.
REQ-005 clk  input  1  sole clock; all state updates on rising edge.
REQ-006 reset_n  input  1  asynchronous, active-low reset.
REQ-007 in_data  input  NUM_IN*WIDTH  channel k occupies bits [k*WIDTH +: WIDTH].
REQ-008 immediate  input  IMM_WIDTH  immediate operand field.
REQ-009 sel  input  SEL_W  channel index for register operand.
REQ-010 imm_en  input  1  1 = choose extended immediate, 0 = choose channel sel.
REQ-011 sext  input  1  1 = sign-extend immediate, 0 = zero-extend.
REQ-012 in_valid  input  1  upstream offers an operand this cycle.
REQ-013 in_ready  output  1  block accepts an operand this cycle.
REQ-014 out_data  output  WIDTH  selected operand, registered.
REQ-015 out_valid  output  1  out_data holds a valid operand.
REQ-016 out_ready  input  1  downstream consumes out_data this cycle.
REQ-017 sel_err  output  1  sticky flag: an out-of-range select was accepted.

Function
REQ-018 The block SHALL transfer an input when in_valid && in_ready on a rising clk edge, and an output when out_valid && out_ready.
REQ-019 The selected value SHALL be: imm_en=1 -> immediate extended to WIDTH (sext=1 replicates bit IMM_WIDTH-1, sext=0 pads zeros); imm_en=0 -> channel sel.
REQ-020 When IMM_WIDTH == WIDTH, the extended immediate SHALL equal immediate unchanged, regardless of sext.
REQ-021 When imm_en=0 and sel >= NUM_IN, the selected value SHALL be all zeros and sel_err SHALL set on the accepting edge.
REQ-022 sel_err SHALL remain 1 until reset; imm_en=1 transfers SHALL never set it, whatever sel is.
REQ-023 Storage SHALL be a 2-entry skid buffer: an output register and one skid register, each with its own valid bit.
REQ-024 Buffer states SHALL be EMPTY (0 entries), ONE (output register only) and FULL (both registers).
REQ-025 in_ready SHALL be 1 in EMPTY and ONE and 0 in FULL; in_ready SHALL be registered and not depend combinationally on out_ready.
REQ-026 out_valid SHALL be 1 in ONE and FULL.
REQ-027 EMPTY + input -> ONE, with the selected value in the output register one cycle after the accepting edge (latency 1).
REQ-028 ONE + input, no output -> FULL, with the new value in the skid register.
REQ-029 ONE + output, no input -> EMPTY.
REQ-030 ONE + input + output on the same edge -> stay ONE, with the new value in the output register (sustained 1 operand/cycle).
REQ-031 FULL + output -> ONE, with the skid value moved to the output register; no input is accepted in FULL.
REQ-032 Ordering SHALL be strictly first-in first-out; no operand is dropped or duplicated.
REQ-033 out_data SHALL stay stable while out_valid=1 and out_ready=0.
REQ-034 Inputs sampled while in_valid=0 SHALL have no effect on state or sel_err.

Reset
REQ-035 Asserting reset_n=0 SHALL immediately force: EMPTY, out_valid=0, in_ready=0, out_data=0, sel_err=0, skid register=0.
REQ-036 On the first rising clk edge after reset_n deasserts, in_ready SHALL go to 1; no transfer SHALL occur on that edge.
REQ-037 Reset asserted mid-transfer SHALL discard all buffered operands with no partial output.

Verification
REQ-038 Defaults, NUM_IN=4; in_data ch2=16'hBEEF; sel=2, imm_en=0, in_valid=1 for one cycle, out_ready=1 -> out_data=16'hBEEF, out_valid=1 on the next cycle only.
REQ-039 Immediate 8'h80, imm_en=1: sext=1 -> out_data=16'hFF80; sext=0 -> 16'h0080; sel_err stays 0.
REQ-040 Hold out_ready=0 and offer A then B -> after two edges in_ready=0 and out_data=A; raise out_ready -> A, then B delivered in order; C offered while FULL is not taken.
REQ-041 in_valid=1 and out_ready=1 continuously with values 1..8 -> eight consecutive output cycles 1..8, with in_ready held at 1.
REQ-042 sel=5 with NUM_IN=4, imm_en=0 -> out_data=16'h0000 and sel_err=1, still 1 after ten further legal transfers.
REQ-043 Pulse reset_n low asynchronously while FULL -> out_valid, in_ready and sel_err go to 0 without a clock edge; neither buffered value is ever output.
